vector_pipeline_ctrl: RTL and testbench

- Central stall/flush sequencer for the 4-register vector pipeline: IF/ID, ID/EX, EX/MEM and MEM/WB.
- Drives the enable and synchronous-clear (reset) inputs of every pipeline register, plus the PC enable.
- Resolves RAW hazards, multi-cycle vector-ALU occupancy of EX, taken branches and data-memory wait states.
- Outputs are Mealy: derived combinationally from the registered FSM state and current-cycle inputs.

---
 rtl/vector_pipeline_ctrl.sv | 163 ++++++++++++++++
 tb/tb_vector_pipeline_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/vector_pipeline_ctrl.sv
// Stall/flush sequencer for the four-register vector pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB).
// Outputs are Mealy: they combine the registered state with this cycle's hazard inputs.
module vector_pipeline_ctrl #(
  parameter int REG_ADDR_W = 4,
  parameter int VLAT       = 4,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic                  ex_valid,
  input  logic                  ex_we,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_multi,
  input  logic                  mem_valid,
  input  logic                  mem_we,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  branch_taken,
  input  logic                  mem_stall,
  output logic                  pc_en,
  output logic                  en_ifid,
  output logic                  en_idex,
  output logic                  en_exmem,
  output logic                  en_memwb,
  output logic                  flush_ifid,
  output logic                  flush_idex,
  output logic                  flush_exmem,
  output logic                  flush_memwb,
  output logic                  busy,
  output logic [15:0]           stall_cycles
);

  typedef enum logic [1:0] {RUN, MULTI, MEMWAIT} state_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(VLAT - 2);

  state_t           state, state_nxt;
  state_t           ret_state, ret_state_nxt;
  state_t           eff_state;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic multi_entry;
  logic multi_hold;
  logic hold;
  logic branch;
  logic ex_fwd, mem_fwd;
  logic rs1_hit, rs2_hit;
  logic raw_hazard;

  // A memory wait resumes evaluation in the saved state within the release cycle.
  assign eff_state = (state == MEMWAIT) ? ret_state : state;

  assign multi_entry = (eff_state == RUN) && ex_valid && ex_multi;
  assign multi_hold  = (eff_state == MULTI) && (cnt != '0);
  assign hold        = multi_entry || multi_hold;
  assign branch      = ex_valid && branch_taken;

  // No WB comparison: the register file writes in the first half-cycle.
  assign ex_fwd  = ex_valid && ex_we;
  assign mem_fwd = mem_valid && mem_we;
  assign rs1_hit = id_rs1_used && ((ex_fwd && (id_rs1 == ex_rd)) || (mem_fwd && (id_rs1 == mem_rd)));
  assign rs2_hit = id_rs2_used && ((ex_fwd && (id_rs2 == ex_rd)) || (mem_fwd && (id_rs2 == mem_rd)));
  assign raw_hazard = id_valid && (rs1_hit || rs2_hit);

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state        <= RUN;
      ret_state    <= RUN;
      cnt          <= '0;
      stall_cycles <= '0;
    end else begin
      state     <= state_nxt;
      ret_state <= ret_state_nxt;
      cnt       <= cnt_nxt;
      if (!pc_en && (stall_cycles != 16'hFFFF))
        stall_cycles <= stall_cycles + 16'd1;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    state_nxt     = state;
    ret_state_nxt = ret_state;
    cnt_nxt       = cnt;
    if (mem_stall) begin
      state_nxt     = MEMWAIT;
      ret_state_nxt = eff_state;
    end else begin
      unique case (eff_state)
        RUN: begin
          if (multi_entry) begin
            state_nxt = MULTI;
            cnt_nxt   = CNT_LOAD;
          end else begin
            state_nxt = RUN;
          end
        end
        MULTI: begin
          if (multi_hold) begin
            state_nxt = MULTI;
            cnt_nxt   = cnt - CNT_W'(1);
          end else begin
            state_nxt = RUN;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  // Output logic
  always_comb begin
    pc_en       = 1'b1;
    en_ifid     = 1'b1;
    en_idex     = 1'b1;
    en_exmem    = 1'b1;
    en_memwb    = 1'b1;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    flush_exmem = 1'b0;
    flush_memwb = 1'b0;
    busy        = (state != RUN);
    if (reset) begin
      pc_en       = 1'b0;
      en_ifid     = 1'b0;
      en_idex     = 1'b0;
      en_exmem    = 1'b0;
      en_memwb    = 1'b0;
      flush_ifid  = 1'b1;
      flush_idex  = 1'b1;
      flush_exmem = 1'b1;
      flush_memwb = 1'b1;
      busy        = 1'b0;
    end else if (mem_stall) begin
      pc_en    = 1'b0;
      en_ifid  = 1'b0;
      en_idex  = 1'b0;
      en_exmem = 1'b0;
      en_memwb = 1'b0;
    end else if (hold) begin
      // EX/MEM is cleared rather than frozen so the op in EX is not duplicated downstream.
      pc_en       = 1'b0;
      en_ifid     = 1'b0;
      en_idex     = 1'b0;
      flush_exmem = 1'b1;
    end else if (branch) begin
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
    end else if (raw_hazard) begin
      pc_en      = 1'b0;
      en_ifid    = 1'b0;
      flush_idex = 1'b1;
    end
  end

endmodule

// File: tb/tb_vector_pipeline_ctrl.sv
// Directed bench for vector_pipeline_ctrl: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares against the DUT outputs.
module tb_vector_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [3:0]  id_rs1, id_rs2;
  logic        id_rs1_used, id_rs2_used;
  logic        ex_valid, ex_we, ex_multi;
  logic [3:0]  ex_rd;
  logic        mem_valid, mem_we;
  logic [3:0]  mem_rd;
  logic        branch_taken, mem_stall;
  logic        pc_en, en_ifid, en_idex, en_exmem, en_memwb;
  logic        flush_ifid, flush_idex, flush_exmem, flush_memwb;
  logic        busy;
  logic [15:0] stall_cycles;

  typedef struct {
    string       name;
    logic [9:0]  outs;
    logic [15:0] sc;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] exp_sc = 16'd0;

  always #5 clk = ~clk;

  vector_pipeline_ctrl #(.REG_ADDR_W(4), .VLAT(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_valid(ex_valid), .ex_we(ex_we), .ex_rd(ex_rd), .ex_multi(ex_multi),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_rd(mem_rd),
    .branch_taken(branch_taken), .mem_stall(mem_stall),
    .pc_en(pc_en), .en_ifid(en_ifid), .en_idex(en_idex), .en_exmem(en_exmem), .en_memwb(en_memwb),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex), .flush_exmem(flush_exmem), .flush_memwb(flush_memwb),
    .busy(busy), .stall_cycles(stall_cycles)
  );

  task automatic check(input string name, input logic [9:0] act_o, input logic [9:0] exp_o,
                       input logic [15:0] act_s, input logic [15:0] exp_s);
    n_cmp++;
    if (act_o !== exp_o || act_s !== exp_s) begin
      n_err++;
      $display("FAIL %s: got outs=%b sc=%h, want outs=%b sc=%h", name, act_o, act_s, exp_o, exp_s);
    end
  endtask

  // Monitor: outputs are valid every cycle; compare whenever an expectation is pending.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check(e.name,
            {pc_en, en_ifid, en_idex, en_exmem, en_memwb,
             flush_ifid, flush_idex, flush_exmem, flush_memwb, busy},
            e.outs, stall_cycles, e.sc);
    end
  end

  task automatic clear_inputs();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
    ex_valid = 0; ex_we = 0; ex_rd = 0; ex_multi = 0;
    mem_valid = 0; mem_we = 0; mem_rd = 0;
    branch_taken = 0; mem_stall = 0;
  endtask

  // Push the expected response for the current cycle, then advance one clock.
  // en/fl bit order: {ifid, idex, exmem, memwb}.
  task automatic expect_cycle(input string name, input bit pc, input bit [3:0] en,
                              input bit [3:0] fl, input bit bsy);
    exp_t e;
    e.name = name;
    e.outs = {pc, en, fl, bsy};
    e.sc   = exp_sc;
    sb.push_back(e);
    if (!reset && !pc && exp_sc != 16'hFFFF) exp_sc = exp_sc + 16'd1;
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    clear_inputs();
    @(posedge clk); #1;
    expect_cycle("reset",      0, 4'b0000, 4'b1111, 0);
    reset = 1'b0;
    expect_cycle("idle",       1, 4'b1111, 4'b0000, 0);

    // Multi-cycle op, VLAT=4: three hold cycles then release.
    ex_valid = 1; ex_we = 1; ex_rd = 4'd9; ex_multi = 1;
    expect_cycle("multi_h1",   0, 4'b0011, 4'b0010, 0);
    expect_cycle("multi_h2",   0, 4'b0011, 4'b0010, 1);
    expect_cycle("multi_h3",   0, 4'b0011, 4'b0010, 1);
    expect_cycle("multi_rel",  1, 4'b1111, 4'b0000, 1);
    clear_inputs();
    expect_cycle("multi_post", 1, 4'b1111, 4'b0000, 0);

    // RAW on rs1=5: EX match then MEM match, then clear.
    id_valid = 1; id_rs1 = 4'd5; id_rs1_used = 1;
    ex_valid = 1; ex_we = 1; ex_rd = 4'd5;
    expect_cycle("raw_ex",     0, 4'b0111, 4'b0100, 0);
    ex_valid = 0; ex_we = 0; mem_valid = 1; mem_we = 1; mem_rd = 4'd5;
    expect_cycle("raw_mem",    0, 4'b0111, 4'b0100, 0);
    mem_valid = 0; mem_we = 0;
    expect_cycle("raw_done",   1, 4'b1111, 4'b0000, 0);

    // Boundaries: unused source or non-writing producer is not a hazard.
    clear_inputs();
    id_valid = 1; id_rs2 = 4'd7; id_rs2_used = 0;
    ex_valid = 1; ex_we = 1; ex_rd = 4'd7;
    expect_cycle("rs2_unused", 1, 4'b1111, 4'b0000, 0);
    id_rs2_used = 1;
    expect_cycle("rs2_hit",    0, 4'b0111, 4'b0100, 0);
    ex_we = 0;
    expect_cycle("ex_no_we",   1, 4'b1111, 4'b0000, 0);

    // Taken branch outranks a concurrent RAW hazard.
    clear_inputs();
    id_valid = 1; id_rs1 = 4'd5; id_rs1_used = 1;
    ex_valid = 1; ex_we = 1; ex_rd = 4'd5; branch_taken = 1;
    expect_cycle("branch_raw", 1, 4'b1111, 4'b1100, 0);
    clear_inputs();

    // Memory stall for 3 cycles in MULTI at cnt=1.
    ex_valid = 1; ex_multi = 1;
    expect_cycle("ms_h1",      0, 4'b0011, 4'b0010, 0);
    expect_cycle("ms_h2",      0, 4'b0011, 4'b0010, 1);
    mem_stall = 1;
    expect_cycle("ms_s1",      0, 4'b0000, 4'b0000, 1);
    expect_cycle("ms_s2",      0, 4'b0000, 4'b0000, 1);
    expect_cycle("ms_s3",      0, 4'b0000, 4'b0000, 1);
    mem_stall = 0;
    expect_cycle("ms_h3",      0, 4'b0011, 4'b0010, 1);
    expect_cycle("ms_rel",     1, 4'b1111, 4'b0000, 1);
    clear_inputs();
    expect_cycle("ms_post",    1, 4'b1111, 4'b0000, 0);

    // Drive stall_cycles up to FFFE with a long memory stall, then check saturation.
    begin
      int n;
      n = 32'hFFFE - int'(exp_sc);
      mem_stall = 1;
      for (int i = 0; i < n; i++) begin
        @(posedge clk); #1;
        if (exp_sc != 16'hFFFF) exp_sc = exp_sc + 16'd1;
      end
    end
    expect_cycle("sat_fffe",   0, 4'b0000, 4'b0000, 1);
    expect_cycle("sat_ffff_a", 0, 4'b0000, 4'b0000, 1);
    expect_cycle("sat_ffff_b", 0, 4'b0000, 4'b0000, 1);
    mem_stall = 0;
    expect_cycle("sat_rel",    1, 4'b1111, 4'b0000, 1);
    expect_cycle("sat_hold",   1, 4'b1111, 4'b0000, 0);

    @(negedge clk); #1;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
